// File: rtl/rs_multi_cdb.sv
// Reservation station with multiple result-broadcast channels.
// Holds up to RS_SIZE decoded instructions between the issue stage and the ALU.
// It wakes pending operands from NUM_CDB broadcast channels and dispatches the
// lowest-indexed ready entry to the ALU each cycle.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   rdy_in               global enable (low = hold all state)
//   clr_in               misprediction flush
//   issue_*              instruction presented by the issue stage
//   cdb_valid/rob_index/value  packed broadcast channels, channel k at slice k
//   rs_full, rs_count    occupancy status
//   exec_*               registered dispatch payload, exec_valid is a 1-cycle pulse
module rs_multi_cdb #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int NUM_CDB   = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           clr_in,
  input  logic                           issue_valid,
  input  logic [ROB_IDX_W-1:0]           issue_rob_index,
  input  logic [OP_W-1:0]                issue_op,
  input  logic [DATA_W-1:0]              issue_rs1_val,
  input  logic [DATA_W-1:0]              issue_rs2_val,
  input  logic                           issue_rs1_has_dep,
  input  logic                           issue_rs2_has_dep,
  input  logic [ROB_IDX_W-1:0]           issue_rs1_dep,
  input  logic [ROB_IDX_W-1:0]           issue_rs2_dep,
  input  logic [DATA_W-1:0]              issue_imm,
  input  logic [DATA_W-1:0]              issue_pc,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_index,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_value,
  output logic                           rs_full,
  output logic [$clog2(RS_SIZE+1)-1:0]   rs_count,
  output logic                           exec_valid,
  output logic [OP_W-1:0]                exec_op,
  output logic [DATA_W-1:0]              exec_rs1,
  output logic [DATA_W-1:0]              exec_rs2,
  output logic [DATA_W-1:0]              exec_imm,
  output logic [DATA_W-1:0]              exec_pc,
  output logic [ROB_IDX_W-1:0]           exec_rob_index
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   pend1;
  logic [RS_SIZE-1:0]   pend2;
  logic [OP_W-1:0]      ent_op   [RS_SIZE];
  logic [DATA_W-1:0]    ent_imm  [RS_SIZE];
  logic [DATA_W-1:0]    ent_pc   [RS_SIZE];
  logic [ROB_IDX_W-1:0] ent_rob  [RS_SIZE];
  logic [DATA_W-1:0]    ent_val1 [RS_SIZE];
  logic [DATA_W-1:0]    ent_val2 [RS_SIZE];
  logic [ROB_IDX_W-1:0] ent_tag1 [RS_SIZE];
  logic [ROB_IDX_W-1:0] ent_tag2 [RS_SIZE];

  logic [CNT_W-1:0]     count;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 issue_acc;
  logic                 byp1_pend;
  logic                 byp2_pend;
  logic [DATA_W-1:0]    byp1_val;
  logic [DATA_W-1:0]    byp2_val;

  assign rs_count = count;
  assign rs_full  = (count == CNT_W'(RS_SIZE));

  // Priority encoders scan downwards so the lowest index is the last one written.
  // Free-slot search uses registered busy, so a slot being dispatched this
  // cycle is still seen as occupied and is not reused until the next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && !pend1[i] && !pend2[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_acc = issue_valid && !rs_full && free_found;

  // Same-cycle bypass: an operand whose producer is broadcasting right now is
  // captured ready. Channels scanned downwards so the lowest channel wins.
  always_comb begin
    byp1_pend = issue_rs1_has_dep;
    byp1_val  = issue_rs1_val;
    byp2_pend = issue_rs2_has_dep;
    byp2_val  = issue_rs2_val;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (issue_rs1_has_dep && cdb_valid[k] &&
          cdb_rob_index[k*ROB_IDX_W +: ROB_IDX_W] == issue_rs1_dep) begin
        byp1_pend = 1'b0;
        byp1_val  = cdb_value[k*DATA_W +: DATA_W];
      end
      if (issue_rs2_has_dep && cdb_valid[k] &&
          cdb_rob_index[k*ROB_IDX_W +: ROB_IDX_W] == issue_rs2_dep) begin
        byp2_pend = 1'b0;
        byp2_val  = cdb_value[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy           <= '0;
      count          <= '0;
      exec_valid     <= 1'b0;
      exec_op        <= '0;
      exec_rs1       <= '0;
      exec_rs2       <= '0;
      exec_imm       <= '0;
      exec_pc        <= '0;
      exec_rob_index <= '0;
    end else if (clr_in) begin
      busy       <= '0;
      count      <= '0;
      exec_valid <= 1'b0;
    end else if (rdy_in) begin
      // Wakeup of busy entries; lowest channel assigned last so it wins.
      for (int e = 0; e < RS_SIZE; e++) begin
        if (busy[e]) begin
          for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (pend1[e] && cdb_valid[k] &&
                ent_tag1[e] == cdb_rob_index[k*ROB_IDX_W +: ROB_IDX_W]) begin
              ent_val1[e] <= cdb_value[k*DATA_W +: DATA_W];
              pend1[e]    <= 1'b0;
            end
            if (pend2[e] && cdb_valid[k] &&
                ent_tag2[e] == cdb_rob_index[k*ROB_IDX_W +: ROB_IDX_W]) begin
              ent_val2[e] <= cdb_value[k*DATA_W +: DATA_W];
              pend2[e]    <= 1'b0;
            end
          end
        end
      end

      // Issue target is never busy, so it cannot collide with wakeup or dispatch.
      if (issue_acc) begin
        busy[free_idx]     <= 1'b1;
        ent_op[free_idx]   <= issue_op;
        ent_imm[free_idx]  <= issue_imm;
        ent_pc[free_idx]   <= issue_pc;
        ent_rob[free_idx]  <= issue_rob_index;
        ent_val1[free_idx] <= byp1_val;
        ent_val2[free_idx] <= byp2_val;
        pend1[free_idx]    <= byp1_pend;
        pend2[free_idx]    <= byp2_pend;
        ent_tag1[free_idx] <= issue_rs1_dep;
        ent_tag2[free_idx] <= issue_rs2_dep;
      end

      // Dispatch stage: payload holds when nothing is selected.
      if (sel_found) begin
        busy[sel_idx]  <= 1'b0;
        exec_valid     <= 1'b1;
        exec_op        <= ent_op[sel_idx];
        exec_rs1       <= ent_val1[sel_idx];
        exec_rs2       <= ent_val2[sel_idx];
        exec_imm       <= ent_imm[sel_idx];
        exec_pc        <= ent_pc[sel_idx];
        exec_rob_index <= ent_rob[sel_idx];
      end else begin
        exec_valid <= 1'b0;
      end

      count <= count + CNT_W'(issue_acc) - CNT_W'(sel_found);
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed self-checking bench for rs_multi_cdb (default parameters).
module tb_rs_multi_cdb;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        issue_valid;
  logic [3:0]  issue_rob_index;
  logic [5:0]  issue_op;
  logic [31:0] issue_rs1_val, issue_rs2_val;
  logic        issue_rs1_has_dep, issue_rs2_has_dep;
  logic [3:0]  issue_rs1_dep, issue_rs2_dep;
  logic [31:0] issue_imm, issue_pc;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_index;
  logic [63:0] cdb_value;
  logic        rs_full;
  logic [4:0]  rs_count;
  logic        exec_valid;
  logic [5:0]  exec_op;
  logic [31:0] exec_rs1, exec_rs2, exec_imm, exec_pc;
  logic [3:0]  exec_rob_index;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  rs_multi_cdb dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .issue_valid(issue_valid), .issue_rob_index(issue_rob_index), .issue_op(issue_op),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_has_dep(issue_rs1_has_dep), .issue_rs2_has_dep(issue_rs2_has_dep),
    .issue_rs1_dep(issue_rs1_dep), .issue_rs2_dep(issue_rs2_dep),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
    .rs_full(rs_full), .rs_count(rs_count), .exec_valid(exec_valid),
    .exec_op(exec_op), .exec_rs1(exec_rs1), .exec_rs2(exec_rs2),
    .exec_imm(exec_imm), .exec_pc(exec_pc), .exec_rob_index(exec_rob_index)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive_issue(input logic [3:0] rob, input logic [5:0] op,
                             input logic [31:0] v1, input logic d1, input logic [3:0] t1,
                             input logic [31:0] v2, input logic d2, input logic [3:0] t2);
    issue_valid       = 1'b1;
    issue_rob_index   = rob;
    issue_op          = op;
    issue_rs1_val     = v1;
    issue_rs1_has_dep = d1;
    issue_rs1_dep     = t1;
    issue_rs2_val     = v2;
    issue_rs2_has_dep = d2;
    issue_rs2_dep     = t2;
  endtask

  task automatic bcast(input logic [1:0] vld, input logic [3:0] tag0, input logic [31:0] val0,
                       input logic [3:0] tag1, input logic [31:0] val1);
    cdb_valid     = vld;
    cdb_rob_index = {tag1, tag0};
    cdb_value     = {val1, val0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
    issue_valid = 1'b0; issue_imm = '0; issue_pc = '0;
    drive_issue(0, 0, 0, 0, 0, 0, 0, 0);
    issue_valid = 1'b0;
    bcast(2'b00, 0, 0, 0, 0);
    step(); step();
    chk("rst_count", 32'(rs_count), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_exec_valid", 32'(exec_valid), 0);
    chk("rst_exec_rs1", exec_rs1, 0);
    chk("rst_exec_rob", 32'(exec_rob_index), 0);
    rst_in = 1'b0;

    // Ready instruction: issue edge, then dispatch on the following edge.
    drive_issue(3, 1, 5, 0, 0, 7, 0, 0);
    step();
    issue_valid = 1'b0;
    chk("add_count_after_issue", 32'(rs_count), 1);
    chk("add_no_early_dispatch", 32'(exec_valid), 0);
    step();
    chk("add_exec_valid", 32'(exec_valid), 1);
    chk("add_exec_rs1", exec_rs1, 5);
    chk("add_exec_rs2", exec_rs2, 7);
    chk("add_exec_rob", 32'(exec_rob_index), 3);
    chk("add_exec_op", 32'(exec_op), 1);
    chk("add_count_after_dispatch", 32'(rs_count), 0);
    rdy_in = 1'b0;
    step();
    chk("rdy_low_holds_exec_valid", 32'(exec_valid), 1);
    rdy_in = 1'b1;
    step();
    chk("exec_valid_pulse_ends", 32'(exec_valid), 0);
    chk("payload_holds", exec_rs1, 5);

    // Dependency on tag 0, woken by channel 1.
    issue_imm = 32'h10; issue_pc = 32'h100;
    drive_issue(2, 4, 0, 1, 0, 1, 0, 0);
    step();
    issue_valid = 1'b0; issue_imm = '0; issue_pc = '0;
    step();
    chk("tag0_pending_count", 32'(rs_count), 1);
    chk("tag0_pending_no_dispatch", 32'(exec_valid), 0);
    bcast(2'b10, 0, 0, 0, 32'hDEAD);
    step();
    bcast(2'b00, 0, 0, 0, 0);
    chk("tag0_not_same_edge", 32'(exec_valid), 0);
    step();
    chk("tag0_exec_valid", 32'(exec_valid), 1);
    chk("tag0_exec_rs1", exec_rs1, 32'hDEAD);
    chk("tag0_exec_rs2", exec_rs2, 1);
    chk("tag0_exec_rob", 32'(exec_rob_index), 2);
    chk("tag0_exec_imm", exec_imm, 32'h10);
    chk("tag0_exec_pc", exec_pc, 32'h100);

    // Both channels match the same tag: channel 0 wins.
    drive_issue(4, 5, 0, 1, 6, 3, 0, 0);
    step();
    issue_valid = 1'b0;
    bcast(2'b11, 6, 32'hAAA, 6, 32'hBBB);
    step();
    bcast(2'b00, 0, 0, 0, 0);
    step();
    chk("dual_exec_valid", 32'(exec_valid), 1);
    chk("dual_lowest_channel", exec_rs1, 32'hAAA);
    chk("dual_exec_rob", 32'(exec_rob_index), 4);

    // Same-cycle issue bypass from channel 0.
    drive_issue(7, 6, 9, 0, 0, 0, 1, 5);
    bcast(2'b01, 5, 32'h42, 0, 0);
    step();
    issue_valid = 1'b0;
    bcast(2'b00, 0, 0, 0, 0);
    chk("byp_count", 32'(rs_count), 1);
    chk("byp_no_early_dispatch", 32'(exec_valid), 0);
    step();
    chk("byp_exec_valid", 32'(exec_valid), 1);
    chk("byp_exec_rs2", exec_rs2, 32'h42);
    chk("byp_exec_rs1", exec_rs1, 9);
    chk("byp_exec_rob", 32'(exec_rob_index), 7);
    step();

    // Fill all 16 entries pending on tag 9.
    for (int i = 0; i < 16; i++) begin
      drive_issue(4'(i), 2, 0, 1, 9, 0, 1, 9);
      step();
    end
    issue_valid = 1'b0;
    chk("fill_count", 32'(rs_count), 16);
    chk("fill_full", 32'(rs_full), 1);
    drive_issue(15, 3, 1, 0, 0, 1, 0, 0);
    step();
    issue_valid = 1'b0;
    chk("full_drop_count", 32'(rs_count), 16);
    step();
    chk("full_no_dispatch", 32'(exec_valid), 0);
    bcast(2'b01, 9, 32'h99, 0, 0);
    step();
    bcast(2'b00, 0, 0, 0, 0);
    chk("drain_wake_edge", 32'(exec_valid), 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_exec_valid", 32'(exec_valid), 1);
      chk("drain_exec_rob", 32'(exec_rob_index), 32'(i));
      chk("drain_exec_op", 32'(exec_op), 2);
      chk("drain_exec_rs1", exec_rs1, 32'h99);
      chk("drain_exec_rs2", exec_rs2, 32'h99);
      chk("drain_count", 32'(rs_count), 32'(15 - i));
      chk("drain_full", 32'(rs_full), 0);
    end
    step();
    chk("drain_done_valid", 32'(exec_valid), 0);
    chk("drain_done_count", 32'(rs_count), 0);

    // rdy low freezes everything, then a flush empties the station.
    drive_issue(1, 1, 0, 1, 12, 0, 0, 0);
    step();
    drive_issue(2, 1, 0, 1, 12, 0, 0, 0);
    step();
    drive_issue(3, 1, 0, 0, 0, 0, 0, 0);
    rdy_in = 1'b0;
    bcast(2'b01, 12, 32'h55, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_count", 32'(rs_count), 2);
      chk("hold_exec_valid", 32'(exec_valid), 0);
    end
    rdy_in = 1'b1;
    issue_valid = 1'b0;
    bcast(2'b00, 0, 0, 0, 0);
    step();
    chk("hold_no_wake", 32'(exec_valid), 0);
    chk("hold_count_after", 32'(rs_count), 2);
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    chk("clr_count", 32'(rs_count), 0);
    chk("clr_exec_valid", 32'(exec_valid), 0);
    chk("clr_full", 32'(rs_full), 0);
    bcast(2'b01, 12, 32'h55, 0, 0);
    step();
    bcast(2'b00, 0, 0, 0, 0);
    step();
    chk("clr_no_dispatch_1", 32'(exec_valid), 0);
    step();
    chk("clr_no_dispatch_2", 32'(exec_valid), 0);

    // Issue and dispatch on the same edge at RS_SIZE-1 occupancy.
    for (int i = 0; i < 14; i++) begin
      drive_issue(4'(i), 2, 0, 1, 9, 0, 1, 9);
      step();
    end
    drive_issue(14, 1, 3, 0, 0, 4, 0, 0);
    step();
    chk("near_full_count", 32'(rs_count), 15);
    chk("near_full_no_dispatch", 32'(exec_valid), 0);
    drive_issue(15, 2, 0, 1, 9, 0, 1, 9);
    step();
    issue_valid = 1'b0;
    chk("swap_count", 32'(rs_count), 15);
    chk("swap_full", 32'(rs_full), 0);
    chk("swap_exec_valid", 32'(exec_valid), 1);
    chk("swap_exec_rob", 32'(exec_rob_index), 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
